// File: rtl/uart_tx.sv
// Serial transmitter with a one-entry holding register.
// The external baud_tick strobe paces every bit; all FSM moves happen on tick edges only.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);
  localparam int               CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_nxt;
  logic                 tx_nxt;
  logic [DATA_BITS-1:0] hold_data, hold_data_nxt;
  logic                 hold_valid, hold_valid_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic                 par_bit, par_nxt;
  logic                 load;

  // Even parity makes the total count of ones even, so the bit is the XOR of the data.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ^d : ~^d;
  endfunction

  assign tx_ready = !hold_valid;
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt      = state;
    tx_nxt         = tx;
    shift_nxt      = shift;
    bit_cnt_nxt    = bit_cnt;
    stop_cnt_nxt   = stop_cnt;
    hold_valid_nxt = hold_valid;
    hold_data_nxt  = hold_data;
    par_nxt        = par_bit;
    load           = 1'b0;
    if (baud_tick) begin
      unique case (state)
        S_IDLE: begin
          if (hold_valid) load = 1'b1;
        end
        S_START: begin
          state_nxt   = S_DATA;
          tx_nxt      = shift[0];
          bit_cnt_nxt = '0;
        end
        S_DATA: begin
          if (bit_cnt != LAST_BIT) begin
            shift_nxt   = shift >> 1;
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            tx_nxt      = shift[1];
          end else if (PARITY != 0) begin
            state_nxt = S_PARITY;
            tx_nxt    = par_bit;
          end else begin
            state_nxt    = S_STOP;
            tx_nxt       = 1'b1;
            stop_cnt_nxt = 1'b0;
          end
        end
        S_PARITY: begin
          state_nxt    = S_STOP;
          tx_nxt       = 1'b1;
          stop_cnt_nxt = 1'b0;
        end
        S_STOP: begin
          if (stop_cnt != LAST_STOP) begin
            stop_cnt_nxt = stop_cnt + 1'b1;
          end else if (hold_valid) begin
            load = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          tx_nxt    = 1'b1;
        end
      endcase
    end
    // Hold-to-shift transfer: shared by the idle start and the gapless back-to-back start.
    if (load) begin
      state_nxt      = S_START;
      tx_nxt         = 1'b0;
      shift_nxt      = hold_data;
      par_nxt        = parity_of(hold_data);
      hold_valid_nxt = 1'b0;
    end
    if (tx_valid && tx_ready) begin
      hold_valid_nxt = 1'b1;
      hold_data_nxt  = tx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      par_bit    <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx         <= tx_nxt;
      hold_data  <= hold_data_nxt;
      hold_valid <= hold_valid_nxt;
      shift      <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      stop_cnt   <= stop_cnt_nxt;
      par_bit    <= par_nxt;
    end
  end
endmodule
